// File: rtl/uart_rx_byte_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_if
// Description : Serial-in / byte-out signal bundle for the UART receiver.
//               master = receiver, slave = downstream byte consumer.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_byte_if;
    logic       rxd;
    logic [7:0] asc;
    logic       start;
    logic       dataerror;
    logic       frameerror;
    logic       busy;

    modport master (
        input  rxd,
        output asc,
        output start,
        output dataerror,
        output frameerror,
        output busy
    );

    modport slave (
        output rxd,
        input  asc,
        input  start,
        input  dataerror,
        input  frameerror,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : LSB-first 8-bit UART receiver, optional parity, one stop bit,
//               counter-based mid-bit sampling. Optional 2-of-3 majority
//               sampling when UART_RX_MAJORITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_byte_if.master rx_if
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT) + 1;

    localparam logic c_par_en  = (PARITY_EN != 0);
    localparam logic c_par_odd = (PARITY_ODD != 0);

    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic               r_rxd_meta;
    logic               r_rxd_s;
    logic               r_rxd_s_d;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par;
    logic [7:0]         r_asc;
    logic               r_start;
    logic               r_dataerror;
    logic               r_frameerror;
    logic               r_busy;

    logic w_bit;
    logic w_tick;
    logic w_shift_en;
    logic w_par_en;
    logic w_stop_en;
    logic w_perr;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_s_d  <= 1'b1;
        end else begin
            r_rxd_meta <= rx_if.rxd;
            r_rxd_s    <= r_rxd_meta;
            r_rxd_s_d  <= r_rxd_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote over sample-1, sample, sample+1; the decision lands one cycle late,
    // so the first sample point moves out by one and every later one follows.
    localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(c_half);

    logic r_rxd_s_d2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxd_s_d2 <= 1'b1;
        end else begin
            r_rxd_s_d2 <= r_rxd_s_d;
        end
    end

    assign w_bit = (r_rxd_s_d2 & r_rxd_s_d) |
                   (r_rxd_s_d2 & r_rxd_s)   |
                   (r_rxd_s_d  & r_rxd_s);
`else
    localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(c_half - 1);

    assign w_bit = r_rxd_s;
`endif

    assign w_fall = r_rxd_s_d & ~r_rxd_s;
    assign w_perr = c_par_en & ((^r_shift ^ r_par) != c_par_odd);

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == c_start_last) begin
                    w_tick      = 1'b1;
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_tick     = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (r_cnt == c_bit_last) begin
                    w_tick      = 1'b1;
                    w_par_en    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_tick      = 1'b1;
                    w_stop_en   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // The counter restarts at every sample point so each bit period is
    // measured from the previous sample rather than from the start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_bit, r_shift[7:1]};
            end
            if (w_par_en) begin
                r_par <= w_bit;
            end
        end
    end

    // Result registers load on the stop sample, so start coincides with DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asc        <= 8'h00;
            r_start      <= 1'b0;
            r_dataerror  <= 1'b0;
            r_frameerror <= 1'b0;
        end else begin
            r_start <= w_stop_en;
            if (w_stop_en) begin
                r_asc        <= r_shift;
                r_dataerror  <= w_perr;
                r_frameerror <= ~w_bit;
            end
        end
    end

    assign rx_if.asc        = r_asc;
    assign rx_if.start      = r_start;
    assign rx_if.dataerror  = r_dataerror;
    assign rx_if.frameerror = r_frameerror;
    assign rx_if.busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receive front end that deserialises the asynchronous rxd line into 8-bit characters. It sits directly upstream of the ASCII-to-number parser. Each received byte is presented on asc with a one-cycle start strobe, plus dataerror (parity) and frameerror (stop bit) flags, matching the parser's input contract. The block is an LSB-first 8-bit receiver with an optional parity bit and one stop bit, using a counter-based mid-bit sampler.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range >= 4.
PARITY_EN, 1, 1 = parity bit follows D7; 0 = no parity bit.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock
rst_n  input  1  one clock; reset is synchronous and active-low
rxd  input  1  asynchronous serial line, idle high
asc  output  8  last received byte
start  output  1  one-cycle strobe: asc and flags are new this cycle
dataerror  output  1  parity mismatch for the byte in asc
frameerror  output  1  stop bit sampled low for the byte in asc
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- rxd passes through a 2-FF synchroniser (rxd_s). Both FFs reset to 1. All logic below uses rxd_s. rxd_s_d is rxd_s delayed by one cycle.
- Reset (rst_n low at a clk edge) values:
  - asc = 0, start = 0, dataerror = 0, frameerror = 0, busy = 0.
  - FSM = IDLE, bit counter = 0, cycle counter = 0.
  - Reset mid-frame aborts the frame; no start strobe is produced.
- HALF = CLKS_PER_BIT/2 (integer division).
- FSM states and transitions:
  - IDLE: a falling edge (rxd_s_d = 1, rxd_s = 0) seen in cycle T0 moves to START_BIT and clears the cycle counter. A line held low does not retrigger; a new high-to-low transition is required.
  - START_BIT: at T0+HALF, sample rxd_s. If 1, it was a false start: return to IDLE with no strobe. If 0, go to DATA and clear the counter.
  - DATA: data bit n (n = 0..7, LSB first) is sampled at T0+HALF+(n+1)*CLKS_PER_BIT and shifted into the shift register. After bit 7, go to PARITY if PARITY_EN, else go to STOP.
  - PARITY: sampled at T0+HALF+9*CLKS_PER_BIT. perr = (^data ^ parity_bit) != PARITY_ODD.
  - STOP: sampled at T0+HALF+(9+PARITY_EN)*CLKS_PER_BIT. Go to DONE.
  - DONE: single cycle. Register asc = shift register, dataerror = perr (0 when PARITY_EN = 0), frameerror = ~stop_sample, and start = 1. Return to IDLE.
- Latency: start rises one cycle after the stop-bit sample.
- Returning to IDLE at mid-stop lets a back-to-back frame be caught: its start edge is detected normally.
- start is high for exactly one cycle per frame, including frames with errors.
- asc, dataerror and frameerror hold their values until the next DONE.
- busy = (state != IDLE), registered with the state.
- Break condition (rxd low for longer than a frame): one frame is reported with frameerror = 1 and asc = 0x00. No further strobes occur until rxd returns high and falls again.
- Cycle counter width: $clog2(CLKS_PER_BIT)+1. It must not wrap inside a bit period.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample point (start, data, parity, stop) uses a 2-of-3 majority vote of rxd_s at sample-1, sample and sample+1. The decision is taken at sample+1, and all later sample points and the start strobe shift by +1 cycle. The false-start check also uses the vote.
- Undefined: a single sample is taken at the sample point. No vote logic is synthesised.

Test Plan:
- CLKS_PER_BIT=8, PARITY_EN=1, even parity. Send 0x30 with parity 0 and stop 1 -> one start pulse, asc=0x30, dataerror=0, frameerror=0; start occurs 1 cycle after T0+4+80.
- Same settings. Send 0x31 with a wrong parity bit (0) -> asc=0x31, dataerror=1, frameerror=0.
- Send 0x61 with stop bit forced 0 -> asc=0x61, frameerror=1, exactly one start pulse. Then hold rxd low for 40 bit times -> no additional pulses. Release high, then send 0x41 -> asc=0x41, no errors.
- Drive a low glitch of 2 cycles on idle rxd -> false start, busy returns to 0, no start pulse.
- Send frames "0","1","a","A" back-to-back with zero idle between frames -> four start pulses, asc = 0x30, 0x31, 0x61, 0x41 in order.
- Assert rst_n=0 during data bit 4, then release and send 0x31 -> no strobe for the aborted frame, all outputs 0 during reset, asc=0x31 afterwards. With UART_RX_MAJORITY_EN defined, add a 1-cycle inverted glitch at bit 2's sample point -> byte still correct.
